// File: rtl/md_stall_ctrl_pkg.sv
// Shared HILO op-class codes and mult/div latencies, so the HILO unit and
// its issue-side controller always agree on encoding and timing.
package md_stall_ctrl_pkg;

  typedef enum logic [3:0] {
    HILO_NONE  = 4'd0,
    HILO_MULT  = 4'd1,
    HILO_MULTU = 4'd2,
    HILO_DIV   = 4'd3,
    HILO_DIVU  = 4'd4,
    HILO_MFHI  = 4'd5,
    HILO_MFLO  = 4'd6,
    HILO_MTHI  = 4'd7,
    HILO_MTLO  = 4'd8
  } hilo_op_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  typedef struct packed {
    logic start;
    logic long_op;
    logic d_md;
  } md_dec_t;

  // Codes 9..15 fall through to the defaults and count as non-HILO.
  function automatic logic is_md_op(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      HILO_MULT, HILO_MULTU, HILO_DIV, HILO_DIVU: r = 1'b1;
      default:                                    r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_long_op(input logic [3:0] op);
    return (op == HILO_DIV) || (op == HILO_DIVU);
  endfunction

  function automatic logic is_hilo_class(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      HILO_MULT, HILO_MULTU, HILO_DIV, HILO_DIVU,
      HILO_MFHI, HILO_MFLO, HILO_MTHI, HILO_MTLO: r = 1'b1;
      default:                                    r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic md_dec_t md_decode(input logic [3:0] d_type,
                                        input logic [3:0] e_type,
                                        input logic       e_flush);
    md_dec_t dec;
    dec.start   = !e_flush && is_md_op(e_type);
    dec.long_op = is_long_op(e_type);
    dec.d_md    = is_hilo_class(d_type);
    return dec;
  endfunction

endpackage

// File: rtl/md_perf_cnt.sv
// Saturating event counter for performance reporting; sticks at all-ones.
module md_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))
      r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/md_stall_ctrl.sv
// Issue-side controller for the E-stage mult/div unit: shadow latency
// countdown, D-stage stall generation, protocol check and stall counter.
module md_stall_ctrl
  import md_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES,
  parameter int CNT_W       = 4,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        D_Type,
  input  logic [3:0]        E_Type,
  input  logic              E_flush,
  output logic              md_stall,
  output logic              md_busy,
  output logic [CNT_W-1:0]  md_remain,
  output logic              proto_err,
  output logic [PERF_W-1:0] stall_cnt
);

  md_dec_t          w_dec;
  logic             w_inflight;
  logic             w_busy;
  logic             w_stall;
  logic [CNT_W-1:0] w_remain_nxt;
  logic [CNT_W-1:0] r_remain;
  logic             r_proto_err;

  assign w_dec      = md_decode(D_Type, E_Type, E_flush);
  assign w_inflight = (r_remain != '0);

  // Busy covers the start cycle itself, so a dependent op in D stalls
  // immediately rather than one cycle late.
  assign w_busy  = w_dec.start || w_inflight;
  assign w_stall = w_dec.d_md && w_busy;

  always_comb begin
    w_remain_nxt = '0;
    if (w_inflight)
      w_remain_nxt = r_remain - CNT_W'(1);
    else if (w_dec.start)
      w_remain_nxt = w_dec.long_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_remain    <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_remain <= w_remain_nxt;
      if (w_dec.start && w_inflight)
        r_proto_err <= 1'b1;
    end
  end

  md_perf_cnt #(
    .W (PERF_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_stall),
    .o_cnt (stall_cnt)
  );

  assign md_stall  = w_stall;
  assign md_busy   = w_busy;
  assign md_remain = r_remain;
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Directed plus random bench for md_stall_ctrl against an absolute-time
// reference model (a started op is busy until a known end cycle).
module tb_md_stall_ctrl;

  localparam int PW  = 6;
  localparam int MC  = 5;
  localparam int DC  = 10;
  localparam int SAT = (1 << PW) - 1;

  localparam logic [3:0] OP_NONE = 4'd0, OP_MULT = 4'd1, OP_DIV = 4'd3,
                         OP_DIVU = 4'd4, OP_MFHI = 4'd5, OP_MFLO = 4'd6,
                         OP_MTHI = 4'd7;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    D_Type, E_Type;
  logic          E_flush;
  logic          md_stall, md_busy, proto_err;
  logic [3:0]    md_remain;
  logic [PW-1:0] stall_cnt;

  md_stall_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4), .PERF_W(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .D_Type    (D_Type),
    .E_Type    (E_Type),
    .E_flush   (E_flush),
    .md_stall  (md_stall),
    .md_busy   (md_busy),
    .md_remain (md_remain),
    .proto_err (proto_err),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_end = 0;
  bit perr = 1'b0;
  int scnt = 0;
  bit known = 1'b0;

  function automatic bit m_start(input logic [3:0] e);
    return (e >= 4'd1) && (e <= 4'd4);
  endfunction

  function automatic bit m_long(input logic [3:0] e);
    return (e == 4'd3) || (e == 4'd4);
  endfunction

  function automatic bit m_dmd(input logic [3:0] d);
    return (d >= 4'd1) && (d <= 4'd8);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Called just after a rising edge: drive, check mid-cycle, then advance.
  task automatic step(input logic rst, input logic [3:0] d, input logic [3:0] e,
                      input logic fl);
    int rem;
    bit st, bz, sl;
    #1;
    reset = rst; D_Type = d; E_Type = e; E_flush = fl;
    #3;
    rem = (busy_end > cyc) ? busy_end - cyc : 0;
    st  = !fl && m_start(e);
    bz  = st || (rem != 0);
    sl  = m_dmd(d) && bz;
    if (known) begin
      chk("md_remain", 32'(md_remain), 32'(rem));
      chk("md_busy",   32'(md_busy),   32'(bz));
      chk("md_stall",  32'(md_stall),  32'(sl));
      chk("proto_err", 32'(proto_err), 32'(perr));
      chk("stall_cnt", 32'(stall_cnt), 32'(scnt));
    end
    @(posedge clk);
    if (!rst) begin
      busy_end = 0; perr = 1'b0; scnt = 0; known = 1'b1;
    end else begin
      if (st && rem == 0) busy_end = cyc + 1 + (m_long(e) ? DC : MC);
      if (st && rem != 0) perr = 1'b1;
      if (sl && scnt < SAT) scnt++;
    end
    cyc++;
  endtask

  initial begin
    logic [3:0] rd, re;
    logic       rr, rf;
    reset = 1'b0; D_Type = OP_NONE; E_Type = OP_MULT; E_flush = 1'b0;

    // reset held two cycles with a mult presented on E
    step(1'b0, OP_NONE, OP_MULT, 1'b0);
    step(1'b0, OP_NONE, OP_MULT, 1'b0);
    #1;
    chk("rst_remain", 32'(md_remain), 32'd0);
    chk("rst_proto",  32'(proto_err), 32'd0);
    chk("rst_cnt",    32'(stall_cnt), 32'd0);

    // mult with mflo waiting in D
    step(1'b1, OP_MFLO, OP_MULT, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, OP_MFLO, OP_NONE, 1'b0);
    #1 chk("mult_stall_cnt", 32'(stall_cnt), 32'd6);

    // divu with a non-HILO op in D never stalls
    step(1'b1, OP_NONE, OP_DIVU, 1'b0);
    #1 chk("divu_load", 32'(md_remain), 32'd10);
    for (int i = 0; i < 11; i++) step(1'b1, OP_NONE, OP_NONE, 1'b0);

    // flushed div neither starts nor busies
    step(1'b1, OP_MFHI, OP_DIV, 1'b1);
    #1 chk("flush_remain", 32'(md_remain), 32'd0);

    // second mult while busy flags proto_err, countdown unaffected
    step(1'b1, OP_NONE, OP_MULT, 1'b0);
    step(1'b1, OP_NONE, OP_NONE, 1'b0);
    step(1'b1, OP_NONE, OP_MULT, 1'b0);
    #1;
    chk("proto_set",  32'(proto_err), 32'd1);
    chk("proto_rem3", 32'(md_remain), 32'd3);
    for (int i = 0; i < 4; i++) step(1'b1, OP_NONE, OP_NONE, 1'b0);

    // reset mid-div, then a fresh mult loads immediately
    step(1'b1, OP_NONE, OP_DIV, 1'b0);
    step(1'b1, OP_NONE, OP_NONE, 1'b0);
    step(1'b1, OP_NONE, OP_NONE, 1'b0);
    step(1'b0, OP_NONE, OP_NONE, 1'b0);
    step(1'b1, OP_NONE, OP_MULT, 1'b0);
    #1;
    chk("rst_mid_load",  32'(md_remain), 32'd5);
    chk("rst_mid_proto", 32'(proto_err), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, OP_NONE, OP_NONE, 1'b0);

    // random traffic, including unknown codes and occasional reset
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 99) != 0);
      rd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15))
                                       : 4'($urandom_range(0, 8));
      if ($urandom_range(0, 5) == 0) re = 4'($urandom_range(1, 4));
      else begin
        re = 4'($urandom_range(0, 11));
        if (re != 4'd0) re = re + 4'd4;
      end
      rf = ($urandom_range(0, 3) == 0);
      step(rr, rd, re, rf);
    end

    // long back-to-back stall run drives the counter into saturation
    step(1'b0, OP_NONE, OP_NONE, 1'b0);
    for (int i = 0; i < SAT + 8; i++) step(1'b1, OP_MTHI, OP_DIV, 1'b0);
    #1;
    chk("stall_sat",   32'(stall_cnt), 32'(SAT));
    chk("sat_proto",   32'(proto_err), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
